// File: rtl/jtvigil_pkg.sv
// Shared constants and types for the Vigilante palette arbiter.
package jtvigil_pkg;

    localparam logic [2:0] SLOT_R    = 3'd0;
    localparam logic [2:0] SLOT_G    = 3'd1;
    localparam logic [2:0] SLOT_B    = 3'd2;
    localparam logic [2:0] SLOT_CPU0 = 3'd3;
    localparam logic [2:0] SLOT_LAST = 3'd7;

    localparam logic [1:0] CH_R = 2'd0;
    localparam logic [1:0] CH_G = 2'd1;
    localparam logic [1:0] CH_B = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PEND = 3'd1,
        ST_ACC  = 3'd2,
        ST_RD   = 3'd3,
        ST_DONE = 3'd4
    } cpu_st_e;

endpackage

// File: rtl/jtvigil_pal_slot.sv
// Pixel-period slot counter with video/CPU slot decode and blank override.
// JTVIGIL_PAL_BLANKFAST_EN hands every slot to the CPU while blanking.
module jtvigil_pal_slot
    import jtvigil_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pxl_cen,
    input  logic       lhbl,
    input  logic       lvbl,
    output logic       blank,
    output logic       vid_fetch,
    output logic [1:0] vid_ch,
    output logic       cap_r,
    output logic       cap_g,
    output logic       cap_b,
    output logic       cpu_next
);

    logic [2:0] slot;
    logic [2:0] slot_nxt;
    logic       video_en;

    always_comb begin
        slot_nxt = slot;
        if (pxl_cen) begin
            slot_nxt = SLOT_R;
        end else if (slot != SLOT_LAST) begin
            slot_nxt = slot + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot <= SLOT_LAST;
        end else begin
            slot <= slot_nxt;
        end
    end

    assign blank = !lhbl || !lvbl;

`ifdef JTVIGIL_PAL_BLANKFAST_EN
    assign video_en = !blank;
`else
    assign video_en = 1'b1;
`endif

    assign vid_fetch = video_en && (slot < SLOT_CPU0);

    always_comb begin
        case (slot)
            SLOT_R:  vid_ch = CH_R;
            SLOT_G:  vid_ch = CH_G;
            default: vid_ch = CH_B;
        endcase
    end

    // RAM data trails its address by one cycle, so captures run one slot late.
    assign cap_r = video_en && (slot == SLOT_G);
    assign cap_g = video_en && (slot == SLOT_B);
    assign cap_b = video_en && (slot == SLOT_CPU0);

    // Grant looks at the slot the access cycle will occupy, never a video one.
    assign cpu_next = !video_en || (slot_nxt >= SLOT_CPU0);

endmodule

// File: rtl/jtvigil_pal_arb.sv
// Palette RAM arbiter: video R/G/B fetch in slots 0-2, CPU access afterwards.
// Optional JTVIGIL_PAL_BLANKFAST_EN gives the CPU every slot during blanking.
module jtvigil_pal_arb
    import jtvigil_pkg::*;
#(
    parameter int AW = 11,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          pxl_cen,
    input  logic          LHBL,
    input  logic          LVBL,
    input  logic [8:0]    pxl_idx,
    input  logic          cpu_cs,
    input  logic          cpu_rnw,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_dout,
    output logic [DW-1:0] cpu_din,
    output logic          cpu_wait,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    output logic          ram_we,
    input  logic [DW-1:0] ram_dout,
    output logic [4:0]    red,
    output logic [4:0]    green,
    output logic [4:0]    blue
);

    logic       blank;
    logic       vid_fetch;
    logic [1:0] vid_ch;
    logic       cap_r;
    logic       cap_g;
    logic       cap_b;
    logic       cpu_next;
    logic [8:0] idx;
    logic [4:0] pre_r;
    logic [4:0] pre_g;
    logic [4:0] pre_b;
    cpu_st_e    state;
    cpu_st_e    state_nxt;

    jtvigil_pal_slot u_slot (
        .clk       (clk),
        .rst_n     (rst_n),
        .pxl_cen   (pxl_cen),
        .lhbl      (LHBL),
        .lvbl      (LVBL),
        .blank     (blank),
        .vid_fetch (vid_fetch),
        .vid_ch    (vid_ch),
        .cap_r     (cap_r),
        .cap_g     (cap_g),
        .cap_b     (cap_b),
        .cpu_next  (cpu_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx <= '0;
        end else if (pxl_cen) begin
            idx <= pxl_idx;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (cpu_cs) state_nxt = cpu_next ? ST_ACC : ST_PEND;
            ST_PEND: begin
                if (!cpu_cs) begin
                    state_nxt = ST_IDLE;
                end else if (cpu_next) begin
                    state_nxt = ST_ACC;
                end
            end
            ST_ACC:  state_nxt = cpu_rnw ? ST_RD : ST_DONE;
            ST_RD:   state_nxt = ST_DONE;
            ST_DONE: if (!cpu_cs) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Write strobe is a flop so a reset mid-access can never leave a partial write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            ram_we  <= 1'b0;
            cpu_din <= '0;
        end else begin
            state  <= state_nxt;
            ram_we <= (state_nxt == ST_ACC) && !cpu_rnw;
            if (state == ST_RD) begin
                cpu_din <= ram_dout;
            end
        end
    end

    assign cpu_wait = rst_n && cpu_cs && (state != ST_DONE);
    assign ram_din  = cpu_dout;

    always_comb begin
        ram_addr = cpu_addr;
        if (state != ST_ACC && vid_fetch) begin
            ram_addr = AW'({idx[8], vid_ch, idx[7:0]});
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_r <= '0;
            pre_g <= '0;
            pre_b <= '0;
        end else begin
            if (cap_r) pre_r <= ram_dout[4:0];
            if (cap_g) pre_g <= ram_dout[4:0];
            if (cap_b) pre_b <= ram_dout[4:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            red   <= '0;
            green <= '0;
            blue  <= '0;
        end else if (pxl_cen) begin
            red   <= blank ? 5'd0 : pre_r;
            green <= blank ? 5'd0 : pre_g;
            blue  <= blank ? 5'd0 : pre_b;
        end
    end

endmodule

// File: tb/tb_jtvigil_pal_arb.sv
// Self-checking bench for jtvigil_pal_arb with a behavioural palette RAM.
module tb_jtvigil_pal_arb;

  localparam int AW = 11;
  localparam int DW = 8;
`ifdef JTVIGIL_PAL_BLANKFAST_EN
  localparam int BLANK_RD_WAIT = 3;
  localparam bit BLANKFAST = 1'b1;
`else
  localparam int BLANK_RD_WAIT = 6;
  localparam bit BLANKFAST = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          pxl_cen;
  logic          LHBL;
  logic          LVBL;
  logic [8:0]    pxl_idx;
  logic          cpu_cs;
  logic          cpu_rnw;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_dout;
  logic [DW-1:0] cpu_din;
  logic          cpu_wait;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic          ram_we;
  logic [DW-1:0] ram_dout;
  logic [4:0]    red;
  logic [4:0]    green;
  logic [4:0]    blue;

  jtvigil_pal_arb #(.AW(AW), .DW(DW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .pxl_cen  (pxl_cen),
    .LHBL     (LHBL),
    .LVBL     (LVBL),
    .pxl_idx  (pxl_idx),
    .cpu_cs   (cpu_cs),
    .cpu_rnw  (cpu_rnw),
    .cpu_addr (cpu_addr),
    .cpu_dout (cpu_dout),
    .cpu_din  (cpu_din),
    .cpu_wait (cpu_wait),
    .ram_addr (ram_addr),
    .ram_din  (ram_din),
    .ram_we   (ram_we),
    .ram_dout (ram_dout),
    .red      (red),
    .green    (green),
    .blue     (blue)
  );

  // palette RAM model with a bench-side preload port
  logic [7:0]    mem [0:2047];
  logic [7:0]    gold [0:2047];
  logic          pre_we = 1'b0;
  logic [AW-1:0] pre_addr = '0;
  logic [7:0]    pre_data = '0;
  logic [AW-1:0] m_addr;
  assign m_addr = pre_we ? pre_addr : ram_addr;

  always @(posedge clk) begin
    if (pre_we) mem[m_addr] <= pre_data;
    else if (ram_we) mem[m_addr] <= ram_din;
    ram_dout <= mem[m_addr];
  end

  // scoreboard state
  int errors = 0;
  int checks = 0;
  logic [15:0] exp_q[$];
  logic [7:0]  rd_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [14:0] model_rgb(input logic [8:0] i);
    return {gold[{i[8], 2'd0, i[7:0]}][4:0],
            gold[{i[8], 2'd1, i[7:0]}][4:0],
            gold[{i[8], 2'd2, i[7:0]}][4:0]};
  endfunction

  // pixel driver: cnt 0 is the pxl_cen cycle, cnt k is slot k-1
  int         cnt = 7;
  logic       vid_on = 1'b0;
  logic [8:0] next_idx = 9'h025;
  logic       next_lhbl = 1'b1;
  logic       next_lvbl = 1'b1;

  initial begin
    pxl_cen = 1'b0;
    pxl_idx = 9'h000;
    LHBL    = 1'b1;
    LVBL    = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (vid_on) begin
        cnt     = (cnt == 7) ? 0 : cnt + 1;
        pxl_cen = (cnt == 0);
        if (cnt == 0) begin
          pxl_idx = next_idx;
          LHBL    = next_lhbl;
          LVBL    = next_lvbl;
        end
      end
    end
  end

  // RGB scoreboard: push at pxl_cen, compare after the following pxl_cen
  logic        cen_q = 1'b0;
  logic        blank_cen = 1'b0;
  logic [15:0] sb_e;
  always @(negedge clk) begin
    if (cen_q) begin
      if (exp_q.size() == 0) begin
        check("rgb_sb_empty", 32'd0, 32'd1);
      end else begin
        sb_e = exp_q.pop_front();
        if (blank_cen) check("rgb_blank", {17'd0, red, green, blue}, 32'd0);
        else if (sb_e[15]) check("rgb", {17'd0, red, green, blue}, {17'd0, sb_e[14:0]});
      end
    end
    cen_q = 1'b0;
    if (vid_on && pxl_cen) begin
      cen_q     = 1'b1;
      blank_cen = !LHBL || !LVBL;
      exp_q.push_back({!(BLANKFAST && blank_cen), model_rgb(pxl_idx)});
    end
  end

  int we_cnt = 0;
  int we_ph = -1;
  always @(negedge clk) begin
    if (ram_we) begin
      we_cnt++;
      we_ph = cnt;
    end
  end

  // driver tasks
  task automatic wait_phase(input int ph);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #2;
      n++;
    end while (cnt != ph && n < 64);
    if (cnt != ph) check("phase_timeout", n, 0);
  endtask

  task automatic cpu_access(input logic rnw, input logic [AW-1:0] addr, input logic [7:0] data,
                            input int exp_wait, input int hold, input string tag);
    int n;
    int we0;
    logic [7:0] e;
    we0 = we_cnt;
    if (rnw) rd_q.push_back(gold[addr]);
    else gold[addr] = data;
    cpu_cs   = 1'b1;
    cpu_rnw  = rnw;
    cpu_addr = addr;
    cpu_dout = data;
    n = 0;
    @(negedge clk);
    while (cpu_wait && n < 64) begin
      n++;
      @(negedge clk);
    end
    check({tag, "_wait"}, n, exp_wait);
    if (rnw) begin
      e = rd_q.pop_front();
      check({tag, "_din"}, {24'd0, cpu_din}, {24'd0, e});
    end
    repeat (hold) @(negedge clk);
    @(posedge clk);
    #2;
    cpu_cs = 1'b0;
    @(posedge clk);
    #2;
    check({tag, "_we_cnt"}, we_cnt - we0, rnw ? 0 : 1);
  endtask

  // watchdog
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int p;
    int s;
    int w;
    int we0;
    logic r;
    logic [AW-1:0] a;
    logic [7:0] d;

    rst_n    = 1'b0;
    cpu_cs   = 1'b1;
    cpu_rnw  = 1'b1;
    cpu_addr = 11'h3FF;
    cpu_dout = 8'h00;

    for (int i = 0; i < 2048; i++) begin
      d = 8'($urandom_range(0, 255));
      if (i == 'h025) d = 8'h11;
      if (i == 'h125) d = 8'h0A;
      if (i == 'h225) d = 8'h1F;
      if (i == 'h3FF) d = 8'h5A;
      gold[i]  = d;
      pre_addr = 11'(i);
      pre_data = d;
      pre_we   = 1'b1;
      @(posedge clk);
      #1;
    end
    pre_we = 1'b0;

    // reset with cs held high
    @(negedge clk);
    check("rst_wait", {31'd0, cpu_wait}, 32'd0);
    check("rst_rgb", {17'd0, red, green, blue}, 32'd0);
    check("rst_din", {24'd0, cpu_din}, 32'd0);
    check("rst_we", {31'd0, ram_we}, 32'd0);

    @(posedge clk);
    #2;
    rst_n = 1'b1;
    cpu_access(1'b1, 11'h3FF, 8'h00, 3, 0, "rst_rd");

    // video fetch of index 0x025
    exp_q.push_back(16'h8000);
    next_idx = 9'h025;
    vid_on   = 1'b1;
    repeat (24) @(posedge clk);
    @(negedge clk);
    check("vid_red", {27'd0, red}, 32'h11);
    check("vid_green", {27'd0, green}, 32'h0A);
    check("vid_blue", {27'd0, blue}, 32'h1F);

    // CPU write landing in slot 3
    wait_phase(3);
    cpu_access(1'b0, 11'h125, 8'h07, 2, 0, "wr_slot3");
    check("wr_we_slot", we_ph, 4);
    repeat (24) @(posedge clk);
    @(negedge clk);
    check("wr_green", {27'd0, green}, 32'h07);

    // CPU read issued with pxl_cen, held off by video slots
    wait_phase(0);
    cpu_access(1'b1, 11'h3FF, 8'h00, 6, 0, "rd_cont");

    // blanking
    next_lhbl = 1'b0;
    wait_phase(0);
    cpu_access(1'b1, 11'h3FF, 8'h00, BLANK_RD_WAIT, 0, "rd_blank");
    wait_phase(1);
    #3;
    check("blank_rgb", {17'd0, red, green, blue}, 32'd0);
    next_lhbl = 1'b1;
    next_lvbl = 1'b0;
    repeat (8) @(posedge clk);
    next_lvbl = 1'b1;
    repeat (24) @(posedge clk);

    // cs held for 20 cycles after completion
    wait_phase(4);
    cpu_access(1'b0, 11'h7F0, 8'hC3, 2, 20, "held");

    // cs dropped while pending
    wait_phase(1);
    we0      = we_cnt;
    cpu_rnw  = 1'b0;
    cpu_addr = 11'h7F1;
    cpu_dout = ~gold[11'h7F1];
    cpu_cs   = 1'b1;
    @(posedge clk);
    #2;
    cpu_cs = 1'b0;
    repeat (10) @(negedge clk);
    check("pend_drop_we", we_cnt - we0, 0);
    check("pend_drop_wait", {31'd0, cpu_wait}, 32'd0);
    wait_phase(5);
    cpu_access(1'b1, 11'h7F1, 8'h00, 3, 0, "pend_rd");

    // random accesses at random slots
    for (int k = 0; k < 12; k++) begin
      next_idx = 9'($urandom_range(0, 511));
      p = $urandom_range(1, 6);
      s = p - 1;
      r = 1'($urandom_range(0, 1));
      a = 11'($urandom_range(0, 2047));
      d = 8'($urandom_range(0, 255));
      w = (s >= 2) ? 2 : 4 - s;
      if (r) w++;
      wait_phase(p);
      cpu_access(r, a, d, w, $urandom_range(0, 3), "rand");
    end

    repeat (24) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
